// File: rtl/vip_pattern_gen_if.sv
// Video stream bundle: raster sync, active strobe and RGB565 pixel.
interface vip_pattern_gen_if;
  logic        frame_vsync;
  logic        frame_hsync;
  logic        frame_de;
  logic [15:0] frame_rgb;

  modport master (output frame_vsync, output frame_hsync, output frame_de, output frame_rgb);
  modport slave  (input  frame_vsync, input  frame_hsync, input  frame_de, input  frame_rgb);
endinterface

// File: rtl/vip_pattern_gen.sv
// Test-pattern video source: raster timing plus colour bars, gray ramp,
// checkerboard or solid colour. Mode/colour/enable are taken only at frame
// boundaries so a frame is never torn. All stream outputs are registered,
// one cycle behind the raster counters.
module vip_pattern_gen #(
  parameter int unsigned H_ACTIVE = 640,
  parameter int unsigned H_FP     = 16,
  parameter int unsigned H_SYNC   = 96,
  parameter int unsigned H_BP     = 48,
  parameter int unsigned V_ACTIVE = 480,
  parameter int unsigned V_FP     = 10,
  parameter int unsigned V_SYNC   = 2,
  parameter int unsigned V_BP     = 33,
  parameter int unsigned CHK_LOG2 = 5
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                en,
  input  logic [1:0]          mode,
  input  logic [15:0]         solid_rgb,
  vip_pattern_gen_if.master   vid,
  output logic [15:0]         frame_cnt,
  output logic                busy
);

  localparam int unsigned H_TOT = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOT = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int unsigned HW    = $clog2(H_TOT);
  localparam int unsigned VW    = $clog2(V_TOT);
  localparam int unsigned BAR_W = H_ACTIVE / 8;
  localparam int unsigned BW    = (BAR_W > 1) ? $clog2(BAR_W) : 1;

  typedef enum logic {IDLE, RUN} state_t;

  state_t          state_q;
  logic [HW-1:0]   h_q, h_d;
  logic [VW-1:0]   v_q, v_d;
  logic [1:0]      mode_q;
  logic [15:0]     solid_q;
  logic [15:0]     frame_cnt_q;
  logic [BW-1:0]   bar_cnt_q;
  logic [2:0]      bar_idx_q;
  logic            vs_q, hs_q, de_q, busy_q;
  logic [15:0]     rgb_q;

  logic            eol, eof;
  logic            h_act, v_act, h_sync, v_sync;
  logic [15:0]     pix;

  // Raster decode of the current counter position.
  always_comb begin
    eol    = (32'(h_q) == H_TOT - 1);
    eof    = eol && (32'(v_q) == V_TOT - 1);
    h_act  = (32'(h_q) < H_ACTIVE);
    v_act  = (32'(v_q) < V_ACTIVE);
    h_sync = (32'(h_q) >= H_ACTIVE + H_FP) && (32'(h_q) < H_ACTIVE + H_FP + H_SYNC);
    v_sync = (32'(v_q) >= V_ACTIVE + V_FP) && (32'(v_q) < V_ACTIVE + V_FP + V_SYNC);
    h_d    = eol ? '0 : h_q + HW'(1);
    v_d    = v_q;
    if (eol) v_d = (32'(v_q) == V_TOT - 1) ? '0 : v_q + VW'(1);
  end

  // Pattern colour for the current position using the frame-latched mode.
  always_comb begin
    pix = '0;
    unique case (mode_q)
      2'd0: begin
        unique case (bar_idx_q)
          3'd0: pix = 16'hFFFF;
          3'd1: pix = 16'hFFE0;
          3'd2: pix = 16'h07FF;
          3'd3: pix = 16'h07E0;
          3'd4: pix = 16'hF81F;
          3'd5: pix = 16'hF800;
          3'd6: pix = 16'h001F;
          default: pix = 16'h0000;
        endcase
      end
      2'd1: pix = {5'(h_q >> 3), 6'(h_q >> 2), 5'(h_q >> 3)};
      2'd2: pix = (1'(h_q >> CHK_LOG2) ^ 1'(v_q >> CHK_LOG2)) ? 16'hFFFF : 16'h0000;
      default: pix = solid_q;
    endcase
  end

  // Frame FSM: counters, frame-boundary latching of mode/colour, frame counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      h_q         <= '0;
      v_q         <= '0;
      mode_q      <= '0;
      solid_q     <= '0;
      frame_cnt_q <= '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          h_q <= '0;
          v_q <= '0;
          if (en) begin
            state_q <= RUN;
            mode_q  <= mode;
            solid_q <= solid_rgb;
          end
        end
        default: begin
          h_q <= h_d;
          v_q <= v_d;
          if (eof) begin
            frame_cnt_q <= frame_cnt_q + 16'd1;
            if (en) begin
              mode_q  <= mode;
              solid_q <= solid_rgb;
            end else begin
              state_q <= IDLE;
            end
          end
        end
      endcase
    end
  end

  // Bar index tracks h_cnt / BAR_W by counting down each bar width instead of dividing.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bar_cnt_q <= BW'(BAR_W - 1);
      bar_idx_q <= '0;
    end else if (state_q != RUN || eol) begin
      bar_cnt_q <= BW'(BAR_W - 1);
      bar_idx_q <= '0;
    end else if (h_act) begin
      if (bar_cnt_q == '0) begin
        bar_cnt_q <= BW'(BAR_W - 1);
        bar_idx_q <= bar_idx_q + 3'd1;
      end else begin
        bar_cnt_q <= bar_cnt_q - BW'(1);
      end
    end
  end

  // Registered stream outputs, one cycle behind the counters, zero outside RUN.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vs_q   <= 1'b0;
      hs_q   <= 1'b0;
      de_q   <= 1'b0;
      rgb_q  <= '0;
      busy_q <= 1'b0;
    end else if (state_q == RUN) begin
      vs_q   <= v_sync;
      hs_q   <= h_sync;
      de_q   <= h_act && v_act;
      rgb_q  <= (h_act && v_act) ? pix : '0;
      busy_q <= 1'b1;
    end else begin
      vs_q   <= 1'b0;
      hs_q   <= 1'b0;
      de_q   <= 1'b0;
      rgb_q  <= '0;
      busy_q <= 1'b0;
    end
  end

  assign vid.frame_vsync = vs_q;
  assign vid.frame_hsync = hs_q;
  assign vid.frame_de    = de_q;
  assign vid.frame_rgb   = rgb_q;
  assign frame_cnt       = frame_cnt_q;
  assign busy            = busy_q;

endmodule

// File: tb/tb_vip_pattern_gen.sv
// Bench for vip_pattern_gen on a small raster (22 x 7 clocks per frame).
// Expected per-cycle stream tuples are queued per frame when the frame's
// mode/colour are issued; a negedge monitor pops one per busy cycle.
module tb_vip_pattern_gen;

  localparam int HA = 16, HF = 2, HS = 2, HB = 2;
  localparam int VA = 4,  VF = 1, VS = 1, VB = 1;
  localparam int CHK = 1;
  localparam int HT = HA + HF + HS + HB;
  localparam int VT = VA + VF + VS + VB;
  localparam int FR = HT * VT;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        en;
  logic [1:0]  mode;
  logic [15:0] solid_rgb;
  logic [15:0] frame_cnt;
  logic        busy;

  vip_pattern_gen_if vid();

  vip_pattern_gen #(
    .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
    .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
    .CHK_LOG2(CHK)
  ) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .mode(mode), .solid_rgb(solid_rgb),
    .vid(vid.master), .frame_cnt(frame_cnt), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        vs;
    logic        hs;
    logic        de;
    logic [15:0] rgb;
    logic [15:0] fcnt;
  } tup_t;

  tup_t        q[$];
  int unsigned n_cmp = 0;
  int unsigned n_bad = 0;
  int unsigned fidx = 0;
  logic [15:0] idle_fcnt = '0;

  function automatic logic [15:0] ref_pix(int m, int x, int y, logic [15:0] s);
    logic [15:0] bars [8];
    int g;
    bars = '{16'hFFFF, 16'hFFE0, 16'h07FF, 16'h07E0, 16'hF81F, 16'hF800, 16'h001F, 16'h0000};
    case (m)
      0: return bars[x / (HA / 8)];
      1: begin
        g = x % 256;
        return 16'(((g / 8) * 2048) + ((g / 4) * 32) + (g / 8));
      end
      2: return ((((x >> CHK) ^ (y >> CHK)) & 1) != 0) ? 16'hFFFF : 16'h0000;
      default: return s;
    endcase
  endfunction

  // Queue the full cycle-by-cycle stream of one frame.
  task automatic push_frame(int m, logic [15:0] s);
    tup_t t;
    int h, v;
    for (int c = 0; c < FR; c++) begin
      h = c % HT;
      v = c / HT;
      t.vs   = (v >= VA + VF) && (v < VA + VF + VS);
      t.hs   = (h >= HA + HF) && (h < HA + HF + HS);
      t.de   = (h < HA) && (v < VA);
      t.rgb  = t.de ? ref_pix(m, h, v, s) : 16'h0000;
      t.fcnt = 16'((c == FR - 1) ? fidx + 1 : fidx);
      q.push_back(t);
    end
    fidx++;
  endtask

  // Begin from IDLE: request a frame, return right after the IDLE->RUN edge.
  task automatic start(int m, logic [15:0] s);
    @(posedge clk);
    #1;
    en = 1'b1;
    mode = 2'(m);
    solid_rgb = s;
    push_frame(m, s);
    @(posedge clk);
  endtask

  // Spend one frame; scramble inputs mid-frame, then set what the next frame latches.
  task automatic body(logic next_en, int nm, logic [15:0] ns);
    repeat (50) @(posedge clk);
    #1;
    en = next_en;
    mode = 2'($urandom);
    solid_rgb = 16'($urandom);
    repeat (70) @(posedge clk);
    #1;
    mode = 2'(nm);
    solid_rgb = ns;
    if (next_en) push_frame(nm, ns);
    repeat (34) @(posedge clk);
  endtask

  // Monitor: busy cycles consume expected tuples; idle cycles must be all zero.
  always @(negedge clk) begin
    tup_t a, e;
    a = {vid.frame_vsync, vid.frame_hsync, vid.frame_de, vid.frame_rgb, frame_cnt};
    if (busy) begin
      n_cmp++;
      if (q.size() == 0) begin
        n_bad++;
        $display("FAIL busy_unexpected t=%0t got vs=%b hs=%b de=%b rgb=%h fcnt=%0d want no frame",
                 $time, a.vs, a.hs, a.de, a.rgb, a.fcnt);
      end else begin
        e = q.pop_front();
        idle_fcnt = e.fcnt;
        if (a !== e) begin
          n_bad++;
          $display("FAIL stream t=%0t got vs=%b hs=%b de=%b rgb=%h fcnt=%0d want vs=%b hs=%b de=%b rgb=%h fcnt=%0d",
                   $time, a.vs, a.hs, a.de, a.rgb, a.fcnt, e.vs, e.hs, e.de, e.rgb, e.fcnt);
        end
      end
    end else begin
      e = {1'b0, 1'b0, 1'b0, 16'h0000, idle_fcnt};
      n_cmp++;
      if (a !== e) begin
        n_bad++;
        $display("FAIL idle_out t=%0t got vs=%b hs=%b de=%b rgb=%h fcnt=%0d want zeros fcnt=%0d pending=%0d",
                 $time, a.vs, a.hs, a.de, a.rgb, a.fcnt, idle_fcnt, q.size());
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog got no finish want finish by %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    en = 1'b0;
    mode = 2'd0;
    solid_rgb = 16'h0000;
    repeat (3) @(posedge clk);
    #3 rst_n = 1'b1;
    repeat (4) @(posedge clk);

    // Chained frames: bars, ramp, checker, solid 1234 then ABCD, random, then drop en.
    start(0, 16'($urandom));
    body(1'b1, 1, 16'($urandom));
    body(1'b1, 2, 16'($urandom));
    body(1'b1, 3, 16'h1234);
    body(1'b1, 3, 16'hABCD);
    for (int i = 0; i < 3; i++) body(1'b1, int'($urandom_range(0, 3)), 16'($urandom));
    body(1'b0, 0, 16'h0000);
    repeat (20) @(posedge clk);

    // Asynchronous reset in the middle of an active line, then restart with en held.
    start(2, 16'($urandom));
    repeat (35) @(posedge clk);
    #3;
    rst_n = 1'b0;
    q.delete();
    fidx = 0;
    idle_fcnt = '0;
    mode = 2'd1;
    solid_rgb = 16'($urandom);
    #1;
    n_cmp++;
    if ({vid.frame_vsync, vid.frame_hsync, vid.frame_de, vid.frame_rgb, frame_cnt, busy} !== 35'd0) begin
      n_bad++;
      $display("FAIL reset_async got vs=%b hs=%b de=%b rgb=%h fcnt=%0d busy=%b want all zero",
               vid.frame_vsync, vid.frame_hsync, vid.frame_de, vid.frame_rgb, frame_cnt, busy);
    end
    repeat (2) @(posedge clk);
    #3;
    push_frame(1, solid_rgb);
    rst_n = 1'b1;
    @(posedge clk);
    body(1'b0, 0, 16'h0000);
    repeat (10) @(posedge clk);

    n_cmp++;
    if (q.size() != 0) begin
      n_bad++;
      $display("FAIL queue_drain got %0d pending want 0", q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
